// File: rtl/cpu_pkg.sv
// Shared front-end definitions: sequencer states, opcode values and opcode classification.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] OP_RTYPE = 8'h33;
  localparam logic [7:0] OP_ITYPE = 8'h03;
  localparam logic [7:0] OP_STYPE = 8'h23;
  localparam logic [7:0] OP_JTYPE = 8'h63;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_R   = 3'd1,
    CLS_I   = 3'd2,
    CLS_S   = 3'd3,
    CLS_J   = 3'd4
  } op_class_t;

  function automatic op_class_t op_class(input logic [7:0] op);
    case (op)
      OP_RTYPE: op_class = CLS_R;
      OP_ITYPE: op_class = CLS_I;
      OP_STYPE: op_class = CLS_S;
      OP_JTYPE: op_class = CLS_J;
      default:  op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the ID-slot load and the instruction in IF.
// Purely combinational, zero latency; no flow control of its own.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       id_valid,
  input  logic [7:0] id_opcode,
  input  logic [4:0] id_wa,
  input  logic [7:0] if_opcode,
  input  logic [4:0] if_ra,
  input  logic [4:0] if_rb,
  output logic       hazard
);

  op_class_t if_cls;
  logic      uses_ra;
  logic      uses_rb;
  logic      id_is_load;

  always_comb begin
    if_cls     = op_class(if_opcode);
    uses_ra    = (if_cls != CLS_NOP);
    // Loads only read ra; rb is a real source for R, S and J forms.
    uses_rb    = (if_cls == CLS_R) || (if_cls == CLS_S) || (if_cls == CLS_J);
    id_is_load = (op_class(id_opcode) == CLS_I);
    hazard     = id_valid && id_is_load && (id_wa != 5'd0) &&
                 ((uses_ra && (if_ra == id_wa)) || (uses_rb && (if_rb == id_wa)));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: PC sequencing, ID slot, load-use bubble and branch redirect.
// pc/ID update one cycle after decision; run_en=0 freezes fetch, a taken branch still redirects.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_en,
  input  logic [7:0]           if_opcode,
  input  logic [4:0]           if_ra,
  input  logic [4:0]           if_rb,
  input  logic [4:0]           if_wa,
  input  logic                 br_taken,
  input  logic [ADDR_BITS-1:0] br_target,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 if_valid,
  output logic                 id_valid,
  output logic                 stall,
  output logic                 flush,
  output logic [15:0]          stall_cnt
);

  localparam logic [ADDR_BITS-1:0] PC_ONE = ADDR_BITS'(1);

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_BITS-1:0] pc_nxt;
  logic                 id_valid_nxt;
  logic [7:0]           id_opcode;
  logic [7:0]           id_opcode_nxt;
  logic [4:0]           id_wa;
  logic [4:0]           id_wa_nxt;
  logic [15:0]          stall_cnt_nxt;
  logic                 hazard;

  hazard_detect u_hazard (
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_wa     (id_wa),
    .if_opcode (if_opcode),
    .if_ra     (if_ra),
    .if_rb     (if_rb),
    .hazard    (hazard)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    id_valid_nxt  = id_valid;
    id_opcode_nxt = id_opcode;
    id_wa_nxt     = id_wa;
    stall_cnt_nxt = stall_cnt;

    // Status outputs are gated by reset so they read 0 while reset is held.
    if_valid = reset && (state == RUN);
    stall    = reset && (state == RUN) && hazard;
    flush    = reset && ((state == RUN) || (state == HOLD)) && br_taken;

    case (state)
      IDLE:      state_nxt = RUN;
      RUN, HOLD: state_nxt = run_en ? RUN : HOLD;
      default:   state_nxt = IDLE;
    endcase

    // Redirect wins over the load-use bubble and over a held front end.
    if (flush) begin
      pc_nxt       = br_target;
      id_valid_nxt = 1'b0;
    end else if (stall) begin
      id_valid_nxt = 1'b0;
      if (stall_cnt != 16'hFFFF) stall_cnt_nxt = stall_cnt + 16'd1;
    end else if ((state == RUN) && run_en) begin
      pc_nxt        = pc + PC_ONE;
      id_valid_nxt  = 1'b1;
      id_opcode_nxt = if_opcode;
      id_wa_nxt     = if_wa;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      id_valid  <= 1'b0;
      id_opcode <= 8'h00;
      id_wa     <= 5'd0;
      stall_cnt <= 16'd0;
    end else begin
      pc        <= pc_nxt;
      id_valid  <= id_valid_nxt;
      id_opcode <= id_opcode_nxt;
      id_wa     <= id_wa_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequencing, load-use stall, flush, wrap, hold.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic [7:0]  if_opcode;
  logic [4:0]  if_ra;
  logic [4:0]  if_rb;
  logic [4:0]  if_wa;
  logic        br_taken;
  logic [6:0]  br_target;
  logic [6:0]  pc;
  logic        if_valid;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_BITS(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .run_en    (run_en),
    .if_opcode (if_opcode),
    .if_ra     (if_ra),
    .if_rb     (if_rb),
    .if_wa     (if_wa),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc),
    .if_valid  (if_valid),
    .id_valid  (id_valid),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic [7:0] op, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] wa);
    if_opcode = op;
    if_ra     = ra;
    if_rb     = rb;
    if_wa     = wa;
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    run_en    = 1'b1;
    br_taken  = 1'b1;
    br_target = 7'h33;
    set_if(8'h13, 5'd0, 5'd0, 5'd0);

    // Reset, with a pending branch that must be ignored
    step();
    step();
    check("rst_pc", pc, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Release: one IDLE cycle, then 0,1,2
    br_taken = 1'b0;
    reset    = 1'b1;
    #1;
    check("idle_if_valid", if_valid, 0);
    check("idle_pc", pc, 0);
    step();
    check("run0_pc", pc, 0);
    check("run0_if_valid", if_valid, 1);
    step();
    check("run1_pc", pc, 1);
    check("run1_id_valid", id_valid, 1);
    step();
    check("run2_pc", pc, 2);
    check("run2_if_valid", if_valid, 1);

    // Load wa=5 into ID, then RTYPE ra=5 in IF
    set_if(8'h03, 5'd0, 5'd0, 5'd5);
    step();
    check("ld5_pc", pc, 3);
    check("ld5_no_stall_ra0", stall, 0);
    set_if(8'h33, 5'd5, 5'd0, 5'd1);
    check("ld5_stall", stall, 1);
    check("ld5_flush", flush, 0);
    step();
    check("ld5_pc_held", pc, 3);
    check("ld5_bubble", id_valid, 0);
    check("ld5_stall_cnt", stall_cnt, 1);
    check("ld5_stall_one_cycle", stall, 0);
    step();
    check("ld5_resume_pc", pc, 4);
    check("ld5_resume_id", id_valid, 1);

    // Load into r0 never stalls
    set_if(8'h03, 5'd0, 5'd0, 5'd0);
    step();
    check("ld0_pc", pc, 5);
    set_if(8'h33, 5'd0, 5'd0, 5'd2);
    check("ld0_no_stall", stall, 0);

    // STYPE rb match stalls
    set_if(8'h03, 5'd0, 5'd0, 5'd7);
    step();
    check("ld7_pc", pc, 6);
    set_if(8'h23, 5'd1, 5'd7, 5'd0);
    check("st_rb_stall", stall, 1);
    step();
    check("st_rb_pc_held", pc, 6);
    check("st_rb_stall_cnt", stall_cnt, 2);

    // Load after load: rb is not a source; NOP class never stalls
    set_if(8'h03, 5'd0, 5'd0, 5'd9);
    check("bubble_no_stall", stall, 0);
    step();
    check("ld9_pc", pc, 7);
    set_if(8'h03, 5'd1, 5'd9, 5'd3);
    check("itype_rb_no_stall", stall, 0);
    set_if(8'h13, 5'd9, 5'd9, 5'd3);
    check("nop_no_stall", stall, 0);

    // Branch in the same cycle as a stall: redirect wins, count unchanged
    set_if(8'h33, 5'd9, 5'd0, 5'd1);
    br_taken  = 1'b1;
    br_target = 7'h40;
    #1;
    check("br_stall_stall", stall, 1);
    check("br_stall_flush", flush, 1);
    step();
    check("br_stall_pc", pc, 7'h40);
    check("br_stall_cnt", stall_cnt, 2);
    check("br_stall_id", id_valid, 0);

    // Wrap from 127 to 0
    set_if(8'h13, 5'd0, 5'd0, 5'd0);
    br_target = 7'd127;
    step();
    check("wrap_pc127", pc, 127);
    br_taken = 1'b0;
    #1;
    check("wrap_flush_low", flush, 0);
    step();
    check("wrap_pc0", pc, 0);
    check("wrap_id", id_valid, 1);

    // Hold at pc=9 for three cycles, then resume
    br_taken  = 1'b1;
    br_target = 7'd9;
    step();
    br_taken = 1'b0;
    run_en   = 1'b0;
    check("hold_pc_start", pc, 9);
    step();
    check("hold1_pc", pc, 9);
    check("hold1_if_valid", if_valid, 0);
    check("hold1_stall", stall, 0);
    step();
    check("hold2_pc", pc, 9);
    step();
    check("hold3_pc", pc, 9);
    check("hold3_cnt", stall_cnt, 2);
    run_en = 1'b1;
    step();
    check("resume_pc9", pc, 9);
    check("resume_if_valid", if_valid, 1);
    step();
    check("resume_pc10", pc, 10);

    // Redirect while held
    run_en = 1'b0;
    step();
    step();
    check("hold_b_pc", pc, 10);
    br_taken  = 1'b1;
    br_target = 7'h20;
    #1;
    check("hold_flush", flush, 1);
    step();
    check("hold_redirect_pc", pc, 7'h20);
    check("hold_redirect_if_valid", if_valid, 0);
    br_taken = 1'b0;
    run_en   = 1'b1;
    step();
    check("hold_b_resume", if_valid, 1);

    // Reset during a pending redirect discards it
    br_taken  = 1'b1;
    br_target = 7'h55;
    reset     = 1'b0;
    #1;
    check("rst_mid_flush", flush, 0);
    step();
    check("rst_mid_pc", pc, 0);
    check("rst_mid_cnt", stall_cnt, 0);
    check("rst_mid_id", id_valid, 0);
    check("rst_mid_if_valid", if_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
